// File: rtl/dff_seq_detector.sv
// Serial 1011 pattern detector on valid-qualified bits.
// Registered match pulse, saturating match counter, observable state.
module dff_seq_detector #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t nxt;
  logic   hit;

  always_comb begin
    nxt = state;
    hit = 1'b0;
    if (din_valid) begin
      unique case (state)
        S0: nxt = din ? S1 : S0;
        S1: nxt = din ? S1 : S2;
        S2: nxt = din ? S3 : S0;
        S3: begin
          if (din) begin
            hit = 1'b1;
            nxt = (OVERLAP != 0) ? S1 : S0;
          end else begin
            nxt = S2;
          end
        end
        default: nxt = S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      match <= 1'b0;
    end else begin
      state <= nxt;
      match <= hit;
    end
  end

  // Clear wins over a simultaneous match; the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_count <= '0;
    end else if (count_clr) begin
      match_count <= '0;
    end else if (hit && match_count != CNT_MAX) begin
      match_count <= match_count + 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_dff_seq_detector.sv
// Scoreboard bench: three detector configurations share one stimulus
// stream and are compared against a bit-history reference model.
module tb_dff_seq_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       count_clr = 1'b0;

  logic       m_ov, m_no, m_sat;
  logic [7:0] c_ov, c_no;
  logic [1:0] c_sat;
  logic [1:0] s_ov, s_no, s_sat;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic m_ov;
    logic m_no;
    logic m_sat;
    int   c_ov;
    int   c_no;
    int   c_sat;
  } exp_t;

  exp_t sb[$];

  logic [3:0] hist;
  int since_ov, since_no;
  int mc_ov, mc_no, mc_sat;

  always #5 clk = ~clk;

  dff_seq_detector #(.OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .count_clr(count_clr), .match(m_ov), .match_count(c_ov),
    .state_o(s_ov)
  );

  dff_seq_detector #(.OVERLAP(0), .CNT_W(8)) dut_no (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .count_clr(count_clr), .match(m_no), .match_count(c_no),
    .state_o(s_no)
  );

  dff_seq_detector #(.OVERLAP(1), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .count_clr(count_clr), .match(m_sat), .match_count(c_sat),
    .state_o(s_sat)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int bump(input int c, input logic m,
                              input logic clr, input int mx);
    if (clr) return 0;
    if (m && c < mx) return c + 1;
    return c;
  endfunction

  task automatic step(input logic v, input logic d,
                      input logic clr, input logic r);
    exp_t e;
    exp_t g;
    logic hit_ov, hit_no;
    @(negedge clk);
    reset = r;
    din_valid = v;
    din = d;
    count_clr = clr;
    hit_ov = 1'b0;
    hit_no = 1'b0;
    if (r) begin
      hist = 4'b0;
      since_ov = 0;
      since_no = 0;
      mc_ov = 0;
      mc_no = 0;
      mc_sat = 0;
    end else begin
      if (v) begin
        hist = {hist[2:0], d};
        since_ov++;
        since_no++;
        hit_ov = (hist == 4'b1011) && (since_ov >= 4);
        hit_no = (hist == 4'b1011) && (since_no >= 4);
        if (hit_no) since_no = 0;
      end
      mc_ov = bump(mc_ov, hit_ov, clr, 255);
      mc_no = bump(mc_no, hit_no, clr, 255);
      mc_sat = bump(mc_sat, hit_ov, clr, 3);
    end
    e.m_ov = hit_ov;
    e.m_no = hit_no;
    e.m_sat = hit_ov;
    e.c_ov = mc_ov;
    e.c_no = mc_no;
    e.c_sat = mc_sat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      g = sb.pop_front();
      chk("match_ov", int'(m_ov), int'(g.m_ov));
      chk("match_no", int'(m_no), int'(g.m_no));
      chk("match_sat", int'(m_sat), int'(g.m_sat));
      chk("count_ov", int'(c_ov), g.c_ov);
      chk("count_no", int'(c_no), g.c_no);
      chk("count_sat", int'(c_sat), g.c_sat);
    end
  endtask

  task automatic bits(input logic [3:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], 1'b0, 1'b0);
  endtask

  initial begin
    hist = 4'b0;
    since_ov = 0;
    since_no = 0;
    mc_ov = 0;
    mc_no = 0;
    mc_sat = 0;

    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_state_ov", int'(s_ov), 0);
    chk("rst_state_no", int'(s_no), 0);

    bits(4'b1011, 4);
    chk("first_match", int'(m_ov), 1);
    chk("first_count", int'(c_ov), 1);
    chk("state_after_ov", int'(s_ov), 1);
    chk("state_after_no", int'(s_no), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pulse_one_cycle", int'(m_ov), 0);

    bits(4'b0011, 3);
    chk("overlap_count", int'(c_ov), 2);
    chk("nonoverlap_count", int'(c_no), 1);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(4'b0101, 3);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0], 1'b0, 1'b0);
      chk("gap_state", int'(s_ov), 3);
      chk("gap_match", int'(m_ov), 0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap_final_match", int'(m_ov), 1);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      bits(4'b1011, 4);
      chk("sat_count", int'(c_sat), (k < 3) ? k : 3);
    end
    bits(4'b0101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_match", int'(m_sat), 1);
    chk("clr_count", int'(c_sat), 0);

    bits(4'b0101, 3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("straddle_match", int'(m_ov), 0);
    chk("straddle_state", int'(s_ov), 1);

    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 199) == 0, $urandom_range(0, 999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
